// File: rtl/imm_pkg.sv
// rtl/imm_pkg.sv - shared format codes, opcode constants and skid states for imm_gen_pipe
//
// Purpose: types and constants used by imm_decode and imm_gen_pipe.
// Ports:   none (package).
// Config:  IMM_BRANCH_SHIFT_EN (consumed by imm_decode).
package imm_pkg;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_D    = 3'd1,
    FMT_CB   = 3'd2,
    FMT_B    = 3'd3,
    FMT_I    = 3'd4
  } fmt_t;

  // Opcode fields, compared against the top bits of the instruction word.
  localparam logic [10:0] OP_LDUR    = 11'b111_1100_0010;  // instr[31:21]
  localparam logic [10:0] OP_STUR    = 11'b111_1100_0000;  // instr[31:21]
  localparam logic [6:0]  OP_CBZ_PFX = 7'b101_1010;        // instr[31:25], CBZ and CBNZ
  localparam logic [5:0]  OP_B       = 6'b000101;          // instr[31:26]
  localparam logic [9:0]  OP_ADDI    = 10'b1001000100;     // instr[31:22]
  localparam logic [9:0]  OP_SUBI    = 10'b1101000100;     // instr[31:22]

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } skid_state_t;

endpackage

// File: rtl/imm_decode.sv
// rtl/imm_decode.sv - combinational LEGv8 format decode and immediate extension
//
// Purpose: classify an instruction word and produce its N-bit extended immediate.
// Ports:
//   instr   in  32  instruction word
//   imm     out N   extended immediate (0 for unrecognised opcodes)
//   fmt     out 3   format code (fmt_t)
//   illegal out 1   opcode not recognised
// Config:  IMM_BRANCH_SHIFT_EN - CB and B immediates are shifted left by 2.
module imm_decode
  import imm_pkg::*;
#(
  parameter int N = 64
) (
  input  logic [31:0]  instr,
  output logic [N-1:0] imm,
  output fmt_t         fmt,
  output logic         illegal
);

  logic [N-1:0] ext_d;
  logic [N-1:0] ext_cb;
  logic [N-1:0] ext_b;
  logic [N-1:0] ext_i;
  logic [N-1:0] br_cb;
  logic [N-1:0] br_b;

  assign ext_d  = {{(N-9){instr[20]}},  instr[20:12]};
  assign ext_cb = {{(N-19){instr[23]}}, instr[23:5]};
  assign ext_b  = {{(N-26){instr[25]}}, instr[25:0]};
  assign ext_i  = {{(N-12){1'b0}},      instr[21:10]};

`ifdef IMM_BRANCH_SHIFT_EN
  // Branch offsets become byte offsets; the shift drops the top two bits.
  assign br_cb = ext_cb << 2;
  assign br_b  = ext_b << 2;
`else
  assign br_cb = ext_cb;
  assign br_b  = ext_b;
`endif

  always_comb begin
    imm     = '0;
    fmt     = FMT_NONE;
    illegal = 1'b0;
    if (instr[31:21] == OP_LDUR || instr[31:21] == OP_STUR) begin
      fmt = FMT_D;
      imm = ext_d;
    end else if (instr[31:25] == OP_CBZ_PFX) begin
      fmt = FMT_CB;
      imm = br_cb;
    end else if (instr[31:26] == OP_B) begin
      fmt = FMT_B;
      imm = br_b;
    end else if (instr[31:22] == OP_ADDI || instr[31:22] == OP_SUBI) begin
      fmt = FMT_I;
      imm = ext_i;
    end else begin
      illegal = 1'b1;
    end
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - registered immediate generator behind a 2-entry skid buffer
//
// Purpose: decode each accepted instruction and present its immediate one cycle later,
//          with ready/valid handshakes on both sides.
// Ports:
//   clk       in  1   rising-edge clock
//   reset     in  1   asynchronous, active-low reset
//   in_valid  in  1   producer has an instruction
//   in_ready  out 1   block can accept an instruction
//   instr     in  32  instruction word
//   out_valid out 1   result is available
//   out_ready in  1   consumer takes the result
//   imm       out N   extended immediate
//   fmt       out 3   format code: 0 NONE, 1 D, 2 CB, 3 B, 4 I
//   illegal   out 1   opcode not recognised
// Config:  IMM_BRANCH_SHIFT_EN (see imm_decode).
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int N = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  instr,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] imm,
  output logic [2:0]   fmt,
  output logic         illegal
);

  skid_state_t state, state_next;

  logic [N-1:0] dec_imm;
  fmt_t         dec_fmt;
  logic         dec_illegal;

  // head is the entry on the outputs; skid holds the one caught while stalled
  logic [N-1:0] head_imm, skid_imm;
  fmt_t         head_fmt, skid_fmt;
  logic         head_illegal, skid_illegal;

  logic in_xfer;
  logic out_xfer;
  logic load_head_in;
  logic load_head_skid;
  logic load_skid;

  imm_decode #(.N(N)) u_decode (
    .instr   (instr),
    .imm     (dec_imm),
    .fmt     (dec_fmt),
    .illegal (dec_illegal)
  );

  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_EMPTY: if (in_xfer) state_next = ST_ONE;
      ST_ONE: begin
        if (in_xfer && !out_xfer) state_next = ST_FULL;
        else if (!in_xfer && out_xfer) state_next = ST_EMPTY;
      end
      ST_FULL:  if (out_xfer) state_next = ST_ONE;
      default:  state_next = ST_EMPTY;
    endcase
  end

  // in_ready depends only on the state register, never on out_ready.
  always_comb begin
    in_ready       = (state != ST_FULL);
    out_valid      = (state != ST_EMPTY);
    load_head_in   = in_xfer && ((state == ST_EMPTY) || (state == ST_ONE && out_xfer));
    load_skid      = in_xfer && (state == ST_ONE) && !out_xfer;
    load_head_skid = (state == ST_FULL) && out_xfer;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_imm     <= '0;
      head_fmt     <= FMT_NONE;
      head_illegal <= 1'b0;
      skid_imm     <= '0;
      skid_fmt     <= FMT_NONE;
      skid_illegal <= 1'b0;
    end else begin
      if (load_head_in) begin
        head_imm     <= dec_imm;
        head_fmt     <= dec_fmt;
        head_illegal <= dec_illegal;
      end else if (load_head_skid) begin
        head_imm     <= skid_imm;
        head_fmt     <= skid_fmt;
        head_illegal <= skid_illegal;
      end
      if (load_skid) begin
        skid_imm     <= dec_imm;
        skid_fmt     <= dec_fmt;
        skid_illegal <= dec_illegal;
      end
    end
  end

  assign imm     = head_imm;
  assign fmt     = head_fmt;
  assign illegal = head_illegal;

endmodule

// File: doc/imm_gen_pipe.md
IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 SHALL have parameter: N, default 64, immediate output width (legal N >= 32).
REQ-002 SHALL have ports:
  - clk  in  1  rising-edge clock.
  - reset  in  1  asynchronous, active-low reset.
  - in_valid  in  1  producer has an instruction.
  - in_ready  out  1  block can accept an instruction.
  - instr  in  32  LEGv8 instruction word.
  - out_valid  out  1  result is available.
  - out_ready  in  1  consumer takes the result.
  - imm  out  N  extended immediate.
  - fmt  out  3  format code: 0 NONE, 1 D, 2 CB, 3 B, 4 I.
  - illegal  out  1  opcode not recognised.

Function
REQ-003 SHALL decode the format from instr as follows:
  - D (LDUR/STUR): instr[31:21] = 111_1100_0010 or 111_1100_0000; imm = sign-extend instr[20:12].
  - CB (CBZ/CBNZ): instr[31:25] = 101_1010; imm = sign-extend instr[23:5].
  - B: instr[31:26] = 000101; imm = sign-extend instr[25:0].
  - I (ADDI/SUBI): instr[31:22] = 1001000100 or 1101000100; imm = zero-extend instr[21:10].
REQ-004 SHALL give any other opcode fmt=0, imm=0 and illegal=1; it still flows through the pipe as a normal entry.
REQ-005 SHALL size extension to N bits via the replication width N minus the field width, with no truncation.
REQ-006 SHALL transfer on the input when in_valid and in_ready are both high on a clk edge.
REQ-007 SHALL transfer on the output when out_valid and out_ready are both high on a clk edge.
REQ-008 SHALL present a result registered one cycle after it is accepted into an empty block.
REQ-009 SHALL sustain throughput of one transfer per cycle while out_ready is held high.
REQ-010 SHALL implement a 2-entry skid buffer with states EMPTY, ONE and FULL:
  - EMPTY -> ONE on input transfer.
  - ONE -> FULL on input transfer without output transfer.
  - ONE -> EMPTY on output transfer without input transfer.
  - ONE stays ONE on simultaneous input and output transfer.
  - FULL -> ONE on output transfer.
REQ-011 SHALL drive in_ready = (state != FULL) from a register, so there is no combinational path from out_ready to in_ready.
REQ-012 SHALL drive out_valid = (state != EMPTY).
REQ-013 SHALL keep imm, fmt and illegal stable while out_valid is high and out_ready is low.
REQ-014 SHALL preserve order: the skid entry is presented only after the head entry leaves.
REQ-015 SHALL ignore instr while in_valid is low or in_ready is low.

Reset
REQ-016 SHALL, while reset is low, force state EMPTY, out_valid=0, in_ready=1, imm=0, fmt=0 and illegal=0.
REQ-017 SHALL drop all in-flight entries when reset is asserted mid-operation, with no partial output afterwards.
REQ-018 SHALL accept an input on the first clk edge after reset deasserts.

Configuration
REQ-019 SHALL, when IMM_BRANCH_SHIFT_EN is defined, output the CB and B immediates shifted left by 2 after sign extension, keeping the low N bits.
REQ-020 SHALL, when IMM_BRANCH_SHIFT_EN is undefined, output all immediates unshifted; D and I formats are unaffected in either case.

Structure
REQ-021 SHALL take the format enum (fmt_t) and the opcode constants (OP_LDUR, OP_STUR, OP_CBZ_PFX, OP_B, OP_ADDI, OP_SUBI) from the shared package imm_pkg.
REQ-022 SHALL place combinational decode and extension in the sub-module imm_decode (instr in; imm, fmt, illegal out); imm_gen_pipe holds only the skid buffer and its state machine.

Verification
REQ-023 SHALL cover LDUR with instr = {111_1100_0010, 9'h1E3, 12'h136}, N=64 -> imm=64'hFFFF_FFFF_FFFF_FFE3, fmt=1, one cycle after accept.
REQ-024 SHALL cover STUR with imm field 9'h0E3 -> imm=64'h0000_0000_0000_00E3, fmt=1.
REQ-025 SHALL cover CBZ with field 19'h5E3FA -> imm=64'hFFFF_FFFF_FFFD_E3FA without the macro, and 64'hFFFF_FFFF_FFF7_8FE8 with IMM_BRANCH_SHIFT_EN.
REQ-026 SHALL cover a stream of 4 back-to-back instructions with out_ready low for 3 cycles:
  - in_ready falls after 2 accepts.
  - outputs are held stable.
  - all 4 emerge in order with no loss or duplication.
REQ-027 SHALL cover instr=32'h0000_0000 -> illegal=1, fmt=0, imm=0; also N=32 with B field 26'h3FF_FFFF -> imm=32'hFFFF_FFFF.
REQ-028 SHALL cover reset pulsed low while FULL -> out_valid=0 and in_ready=1 immediately (asynchronous), with no stale output after release.
